// File: rtl/mmu_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmu_mem_responder_if
//  Description : Core/MMU-side memory bus carrying instruction reads, data
//                reads, strobed data writes, the preload port and MEM_WAIT.
//                master = requester (core / bench), slave = memory responder.
//  Signals     : mem_wait                               slave -> master
//                inst_rden, inst_riaddr                 master -> slave
//                inst_roaddr, inst_rvalid, inst_rdata   slave -> master
//                data_rden, data_riaddr                 master -> slave
//                data_roaddr, data_rvalid, data_rdata   slave -> master
//                data_wren, data_waddr, data_wstrb,
//                data_wdata                             master -> slave
//                load_en, load_addr, load_data          master -> slave
//  Revision    : 1.0  initial release
// ============================================================================
interface mmu_mem_responder_if;
    logic        mem_wait;

    logic        inst_rden;
    logic [31:0] inst_riaddr;
    logic [31:0] inst_roaddr;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    logic        data_rden;
    logic [31:0] data_riaddr;
    logic [31:0] data_roaddr;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    logic        data_wren;
    logic [31:0] data_waddr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;

    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    modport master (
        input  mem_wait,
        output inst_rden, inst_riaddr,
        input  inst_roaddr, inst_rvalid, inst_rdata,
        output data_rden, data_riaddr,
        input  data_roaddr, data_rvalid, data_rdata,
        output data_wren, data_waddr, data_wstrb, data_wdata,
        output load_en, load_addr, load_data
    );

    modport slave (
        output mem_wait,
        input  inst_rden, inst_riaddr,
        output inst_roaddr, inst_rvalid, inst_rdata,
        input  data_rden, data_riaddr,
        output data_roaddr, data_rvalid, data_rdata,
        input  data_wren, data_waddr, data_wstrb, data_wdata,
        input  load_en, load_addr, load_data
    );
endinterface
`default_nettype wire

// File: rtl/mmu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mmu_mem_responder
//  Description : Memory-side responder for the core/MMU fetch and load/store
//                bus. One on-chip word array serves instruction reads, data
//                reads, strobed data writes and a preload (LOAD) port.
//  Parameters  : ADDR_WIDTH  word-address bits (capacity 4*2^ADDR_WIDTH bytes)
//                BASE_ADDR   byte address of word 0
//                LATENCY     cycles from acceptance to RVALID, legal 1..4
//  Ports       : clk         rising-edge clock
//                rst_n       asynchronous active-low reset
//                bus         mmu_mem_responder_if.slave (requests, responses,
//                            mem_wait, preload port)
//  Revision    : 1.0  initial release
// ============================================================================
module mmu_mem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mmu_mem_responder_if.slave bus
);
    localparam logic [32:0] c_span = 33'd4 << ADDR_WIDTH;   // bytes covered
    localparam int          c_ent_w = 65;                    // {valid, addr, data}
    localparam int          c_sr_w  = c_ent_w * LATENCY;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DEFER = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return ({1'b0, off} < c_span);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[ADDR_WIDTH+1:2];
    endfunction

    logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_mem_wait;
    logic [31:0]           r_skid_addr;

    logic                  w_acc_inst;
    logic                  w_acc_rd;
    logic                  w_acc_wr;
    logic                  w_skid_cap;
    logic                  w_data_issue;
    logic [31:0]           w_data_raddr;
    logic [31:0]           w_inst_word;
    logic [31:0]           w_data_word;

    logic                  w_we;
    logic [31:0]           w_waddr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wstrb;
    logic [ADDR_WIDTH-1:0] w_widx;
    logic [31:0]           w_wword;

    logic [c_sr_w-1:0]     r_inst_sr;
    logic [c_sr_w-1:0]     r_data_sr;
    logic [c_ent_w-1:0]    w_inst_out;
    logic [c_ent_w-1:0]    w_data_out;

    // ------------------------------------------------------------------------
    // Control FSM. A LOAD request outranks everything; in RUN it also blocks
    // acceptance of INST/DATA requests in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_acc_inst   = 1'b0;
        w_acc_rd     = 1'b0;
        w_acc_wr     = 1'b0;
        w_skid_cap   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.load_en) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_acc_inst = bus.inst_rden;
                    w_acc_wr   = bus.data_wren;
                    w_acc_rd   = bus.data_rden & ~bus.data_wren;
                    // Read colliding with a write is parked and replayed next
                    // cycle so it observes the write.
                    w_skid_cap = bus.data_rden & bus.data_wren;
                    if (w_skid_cap) begin
                        w_next_state = ST_DEFER;
                    end
                end
            end
            ST_DEFER: w_next_state = bus.load_en ? ST_LOAD : ST_RUN;
            ST_LOAD:  w_next_state = bus.load_en ? ST_LOAD : ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_mem_wait  <= 1'b0;
            r_skid_addr <= '0;
        end else begin
            r_state    <= w_next_state;
            r_mem_wait <= (w_next_state != ST_RUN);
            if (w_skid_cap) begin
                r_skid_addr <= bus.data_riaddr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Array write port, shared by preload and data writes (never both in one
    // cycle because LOAD blocks data acceptance). Unstrobed bytes keep their
    // current contents.
    // ------------------------------------------------------------------------
    always_comb begin
        w_waddr = bus.load_en ? bus.load_addr : bus.data_waddr;
        w_wdata = bus.load_en ? bus.load_data : bus.data_wdata;
        w_wstrb = bus.load_en ? 4'hF          : bus.data_wstrb;
        w_widx  = word_index(w_waddr);
        w_we    = (bus.load_en | w_acc_wr) & addr_in_range(w_waddr);
        w_wword = r_mem[w_widx];
        for (int b = 0; b < 4; b++) begin
            if (w_wstrb[b]) begin
                w_wword[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_widx] <= w_wword;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports. Reads sample the array before the same-edge write lands,
    // so an INST read racing a DATA write to the same word gets old data.
    // ------------------------------------------------------------------------
    assign w_data_issue = w_acc_rd | (r_state == ST_DEFER);
    assign w_data_raddr = (r_state == ST_DEFER) ? r_skid_addr : bus.data_riaddr;

    assign w_inst_word = addr_in_range(bus.inst_riaddr) ? r_mem[word_index(bus.inst_riaddr)] : '0;
    assign w_data_word = addr_in_range(w_data_raddr)    ? r_mem[word_index(w_data_raddr)]    : '0;

    // ------------------------------------------------------------------------
    // Response pipelines: LATENCY-deep shift registers of {valid, addr, data}.
    // The newest entry enters at the bottom; the top entry drives the bus.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_sr <= '0;
            r_data_sr <= '0;
        end else begin
            r_inst_sr <= (c_sr_w)'({r_inst_sr, w_acc_inst,   bus.inst_riaddr, w_inst_word});
            r_data_sr <= (c_sr_w)'({r_data_sr, w_data_issue, w_data_raddr,    w_data_word});
        end
    end

    assign w_inst_out = r_inst_sr[c_sr_w-1 -: c_ent_w];
    assign w_data_out = r_data_sr[c_sr_w-1 -: c_ent_w];

    assign bus.mem_wait    = r_mem_wait;
    assign bus.inst_rvalid = w_inst_out[64];
    assign bus.inst_roaddr = w_inst_out[63:32];
    assign bus.inst_rdata  = w_inst_out[31:0];
    assign bus.data_rvalid = w_data_out[64];
    assign bus.data_roaddr = w_data_out[63:32];
    assign bus.data_rdata  = w_data_out[31:0];

endmodule
`default_nettype wire

// File: tb/tb_mmu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmu_mem_responder
//  Description : Self-checking bench for mmu_mem_responder. A behavioural
//                model (word array + per-channel response queues stamped
//                with their due cycle) predicts every response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmu_mem_responder;
    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          LAT  = 2;
    localparam logic [31:0] SPAN = 32'd4 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmu_mem_responder_if ifc ();

    mmu_mem_responder #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } resp_t;

    resp_t       iq[$];
    resp_t       dq[$];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    int          cyc = 0;
    bit          m_wait = 1'b0;
    bit          m_defer = 1'b0;
    logic [31:0] m_skid = '0;
    bit          exp_iv, exp_dv;
    logic [31:0] exp_ia, exp_id, exp_da, exp_dd;

    // ---------------- reference model ----------------
    function automatic resp_t mk(input int due, input logic [31:0] a, input logic [31:0] d);
        resp_t r;
        r.due = due; r.addr = a; r.data = d;
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= SPAN) return 32'h0;
        return ref_mem[off / 4];
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] off;
        off = a - BASE;
        if (off < SPAN) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[off / 4][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic model_reset();
        iq.delete();
        dq.delete();
        m_wait  = 1'b0;
        m_defer = 1'b0;
    endtask

    // Applies the rules for one rising edge using the inputs the DUT sees.
    task automatic model_edge();
        bit acc;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = !m_wait && !ifc.load_en;
        // all reads of an edge see the memory as it was before that edge
        if (m_defer)
            dq.push_back(mk(cyc + LAT - 1, m_skid, ref_read(m_skid)));
        if (acc && ifc.inst_rden)
            iq.push_back(mk(cyc + LAT - 1, ifc.inst_riaddr, ref_read(ifc.inst_riaddr)));
        if (acc && ifc.data_rden && !ifc.data_wren)
            dq.push_back(mk(cyc + LAT - 1, ifc.data_riaddr, ref_read(ifc.data_riaddr)));
        if (acc && ifc.data_wren)
            ref_write(ifc.data_waddr, ifc.data_wdata, ifc.data_wstrb);
        if (ifc.load_en)
            ref_write(ifc.load_addr, ifc.load_data, 4'hF);
        m_defer = acc && ifc.data_rden && ifc.data_wren;
        if (m_defer) m_skid = ifc.data_riaddr;
        m_wait = ifc.load_en || m_defer;
    endtask

    task automatic model_outputs();
        resp_t r;
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        if (iq.size() > 0 && iq[0].due == cyc) begin
            r = iq.pop_front();
            exp_iv = 1'b1; exp_ia = r.addr; exp_id = r.data;
        end
        if (dq.size() > 0 && dq[0].due == cyc) begin
            r = dq.pop_front();
            exp_dv = 1'b1; exp_da = r.addr; exp_dd = r.data;
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_outputs();
    endtask

    task automatic idle();
        ifc.inst_rden   = 1'b0; ifc.inst_riaddr = '0;
        ifc.data_rden   = 1'b0; ifc.data_riaddr = '0;
        ifc.data_wren   = 1'b0; ifc.data_waddr  = '0;
        ifc.data_wstrb  = '0;   ifc.data_wdata  = '0;
        ifc.load_en     = 1'b0; ifc.load_addr   = '0;
        ifc.load_data   = '0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'h300 + 32'($urandom_range(15, 0)) * 4 + 32'($urandom_range(3, 0));
        case ($urandom_range(7, 0))
            0:       a = a + SPAN;                                  // aliases onto the window if unchecked
            1:       a = SPAN - 4 + 32'($urandom_range(3, 0));      // last valid word
            default: ;
        endcase
        return BASE + a;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        checks++;
        if ({ifc.mem_wait, ifc.inst_rvalid, ifc.data_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b exp 000", ifc.mem_wait, ifc.inst_rvalid, ifc.data_rvalid);
        end
        checks++;
        if ({ifc.inst_roaddr, ifc.inst_rdata, ifc.data_roaddr, ifc.data_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_buses got %h %h %h %h exp 0", ifc.inst_roaddr, ifc.inst_rdata, ifc.data_roaddr, ifc.data_rdata);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (ifc.mem_wait !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_wait got %b exp 0", ifc.mem_wait);
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < (1 << AW); i++) begin
            ifc.load_en   = 1'b1;
            ifc.load_addr = BASE + 32'(i) * 4;
            ifc.load_data = (i < 4) ? 32'hA0 + 32'(i) : (i == 64) ? 32'h1122_3344 : $urandom;
            step();
            checks++;
            if (ifc.mem_wait !== 1'b1) begin
                errors++;
                $display("FAIL load_wait word %0d got %b exp 1", i, ifc.mem_wait);
            end
        end
        ifc.load_en = 1'b0;
        step();
        checks++;
        if (ifc.mem_wait !== 1'b0) begin
            errors++;
            $display("FAIL load_exit_wait got %b exp 0", ifc.mem_wait);
        end
        ifc.inst_rden = 1'b1; ifc.inst_riaddr = BASE + 32'h4;
        step();
        idle();
        for (int k = 1; k < LAT; k++) begin
            checks++;
            if (ifc.inst_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL load_read_early got %b exp 0", ifc.inst_rvalid);
            end
            step();
        end
        checks++;
        if (ifc.inst_rvalid !== 1'b1 || ifc.inst_roaddr !== BASE + 32'h4 || ifc.inst_rdata !== 32'hA1) begin
            errors++;
            $display("FAIL load_read got v=%b a=%h d=%h exp v=1 a=%h d=000000a1",
                     ifc.inst_rvalid, ifc.inst_roaddr, ifc.inst_rdata, BASE + 32'h4);
        end
    endtask

    task automatic test_back_to_back();
        int j;
        for (int t = 0; t < LAT + 4; t++) begin
            ifc.inst_rden   = (t < 3);
            ifc.inst_riaddr = BASE + 32'(t) * 4;
            step();
            checks++;
            if (t >= LAT - 1 && t <= LAT + 1) begin
                j = t - (LAT - 1);
                if (ifc.inst_rvalid !== 1'b1 || ifc.inst_roaddr !== BASE + 32'(j) * 4 ||
                    ifc.inst_rdata !== 32'hA0 + 32'(j)) begin
                    errors++;
                    $display("FAIL b2b_resp%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", j, ifc.inst_rvalid,
                             ifc.inst_roaddr, ifc.inst_rdata, BASE + 32'(j) * 4, 32'hA0 + 32'(j));
                end
            end else if (ifc.inst_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle t=%0d got %b exp 0", t, ifc.inst_rvalid);
            end
        end
        idle();
    endtask

    task automatic test_strobe();
        ifc.data_wren = 1'b1; ifc.data_waddr = BASE + 32'h100;
        ifc.data_wdata = 32'hDEAD_BEEF; ifc.data_wstrb = 4'b0011;
        step();
        idle();
        ifc.data_rden = 1'b1; ifc.data_riaddr = BASE + 32'h100;
        step();
        idle();
        checks++;
        if (ifc.mem_wait !== 1'b0) begin
            errors++;
            $display("FAIL strobe_wait_pending got %b exp 0", ifc.mem_wait);
        end
        for (int k = 1; k < LAT; k++) step();
        checks++;
        if (ifc.data_rvalid !== 1'b1 || ifc.data_roaddr !== BASE + 32'h100 || ifc.data_rdata !== 32'h1122_BEEF) begin
            errors++;
            $display("FAIL strobe_read got v=%b a=%h d=%h exp v=1 d=1122beef", ifc.data_rvalid, ifc.data_roaddr, ifc.data_rdata);
        end
    endtask

    task automatic test_defer();
        ifc.data_rden = 1'b1; ifc.data_riaddr = BASE + 32'h200;
        ifc.data_wren = 1'b1; ifc.data_waddr  = BASE + 32'h200;
        ifc.data_wdata = 32'h55AA_55AA; ifc.data_wstrb = 4'hF;
        step();
        idle();
        checks++;
        if (ifc.mem_wait !== 1'b1 || ifc.data_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL defer_enter got wait=%b v=%b exp wait=1 v=0", ifc.mem_wait, ifc.data_rvalid);
        end
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k == 1) begin
                checks++;
                if (ifc.mem_wait !== 1'b0) begin
                    errors++;
                    $display("FAIL defer_wait_len got %b exp 0", ifc.mem_wait);
                end
            end
            checks++;
            if (k < LAT) begin
                if (ifc.data_rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL defer_early k=%0d got %b exp 0", k, ifc.data_rvalid);
                end
            end else if (ifc.data_rvalid !== 1'b1 || ifc.data_roaddr !== BASE + 32'h200 || ifc.data_rdata !== 32'h55AA_55AA) begin
                errors++;
                $display("FAIL defer_read got v=%b a=%h d=%h exp v=1 d=55aa55aa", ifc.data_rvalid, ifc.data_roaddr, ifc.data_rdata);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [2];
        logic [31:0] want  [2];
        addrs[0] = BASE + 32'h0001_0000; want[0] = 32'h0;
        addrs[1] = BASE;                 want[1] = 32'hA0;
        ifc.data_wren = 1'b1; ifc.data_waddr = addrs[0];
        ifc.data_wdata = 32'hCAFE_F00D; ifc.data_wstrb = 4'hF;
        step();
        idle();
        for (int n = 0; n < 2; n++) begin
            ifc.data_rden = 1'b1; ifc.data_riaddr = addrs[n];
            step();
            idle();
            for (int k = 1; k < LAT; k++) step();
            checks++;
            if (ifc.data_rvalid !== 1'b1 || ifc.data_roaddr !== addrs[n] || ifc.data_rdata !== want[n]) begin
                errors++;
                $display("FAIL oor_read%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", n, ifc.data_rvalid,
                         ifc.data_roaddr, ifc.data_rdata, addrs[n], want[n]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ifc.inst_rden = 1'b1; ifc.inst_riaddr = BASE + 32'h8;
        ifc.data_rden = 1'b1; ifc.data_riaddr = BASE + 32'h100;
        step();
        idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ifc.mem_wait, ifc.inst_rvalid, ifc.data_rvalid} !== 3'b000 ||
            {ifc.inst_roaddr, ifc.inst_rdata, ifc.data_roaddr, ifc.data_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL midreset_outputs got w=%b iv=%b dv=%b ia=%h id=%h da=%h dd=%h exp all 0", ifc.mem_wait,
                     ifc.inst_rvalid, ifc.data_rvalid, ifc.inst_roaddr, ifc.inst_rdata, ifc.data_roaddr, ifc.data_rdata);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            step();
            checks++;
            if (ifc.inst_rvalid !== 1'b0 || ifc.data_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale k=%0d got iv=%b dv=%b exp 0 0", k, ifc.inst_rvalid, ifc.data_rvalid);
            end
        end
    endtask

    task automatic test_random(input int n);
        int burst = 0;
        for (int t = 0; t < n + LAT + 2; t++) begin
            if (t < n) begin
                if (burst == 0 && $urandom_range(39, 0) == 0) burst = $urandom_range(4, 1);
                ifc.load_en     = (burst > 0);
                if (burst > 0) burst--;
                ifc.load_addr   = rnd_addr();
                ifc.load_data   = $urandom;
                ifc.inst_rden   = 1'($urandom_range(1, 0));
                ifc.inst_riaddr = rnd_addr();
                ifc.data_rden   = 1'($urandom_range(1, 0));
                ifc.data_riaddr = rnd_addr();
                ifc.data_wren   = ($urandom_range(2, 0) == 0);
                ifc.data_waddr  = rnd_addr();
                ifc.data_wdata  = $urandom;
                ifc.data_wstrb  = 4'($urandom);
            end else begin
                idle();
            end
            step();
            checks++;
            if (ifc.mem_wait !== m_wait) begin
                errors++;
                $display("FAIL rnd_wait cyc %0d got %b exp %b", cyc, ifc.mem_wait, m_wait);
            end
            checks++;
            if (ifc.inst_rvalid !== exp_iv || (exp_iv && (ifc.inst_roaddr !== exp_ia || ifc.inst_rdata !== exp_id))) begin
                errors++;
                $display("FAIL rnd_inst cyc %0d got v=%b a=%h d=%h exp v=%b a=%h d=%h", cyc,
                         ifc.inst_rvalid, ifc.inst_roaddr, ifc.inst_rdata, exp_iv, exp_ia, exp_id);
            end
            checks++;
            if (ifc.data_rvalid !== exp_dv || (exp_dv && (ifc.data_roaddr !== exp_da || ifc.data_rdata !== exp_dd))) begin
                errors++;
                $display("FAIL rnd_data cyc %0d got v=%b a=%h d=%h exp v=%b a=%h d=%h", cyc,
                         ifc.data_rvalid, ifc.data_roaddr, ifc.data_rdata, exp_dv, exp_da, exp_dd);
            end
        end
        checks++;
        if (iq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain got %0d/%0d responses outstanding exp 0/0", iq.size(), dq.size());
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_strobe();
        test_defer();
        test_out_of_range();
        test_reset_mid();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
